// File: rtl/job_feeder_pkg.sv
// Shared types for the BLAKE3 job feeder: FSM states, latched job record,
// and the flag-word bit positions used by the hash generator.
package job_feeder_pkg;

   localparam int FLG_CS   = 0;
   localparam int FLG_CE   = 1;
   localparam int FLG_ROOT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [7:0][31:0]  h;
      logic [15:0][31:0] msg;
      logic [31:0]       bl;
      logic [2:0]        flg;
      logic [31:0]       nonce;
      logic [31:0]       cnt;
   } job_t;

   function automatic logic [15:0][31:0] insert_nonce(input logic [15:0][31:0] msg,
                                                      input logic [3:0] idx,
                                                      input logic [31:0] nonce);
      logic [15:0][31:0] r;
      r      = msg;
      r[idx] = nonce;
      return r;
   endfunction

endpackage

// File: rtl/job_feeder_issue_timer.sv
// Loadable down-counter; tick is high once the loaded gap has elapsed.
module issue_timer #(
   parameter int W = 32
) (
   input  logic         Clk,
   input  logic         Rstn_I,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick
);

   logic [W-1:0] cnt;

   always_ff @(posedge Clk or negedge Rstn_I) begin
      if (!Rstn_I)          cnt <= '0;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/job_feeder.sv
// Accepts one mining job and issues nonce-stamped message blocks to the
// BLAKE3 hash generator, one per issue slot, until the count runs out or abort.
module job_feeder
   import job_feeder_pkg::*;
#(
   parameter int NONCE_IDX      = 0,
   parameter int ISSUE_INTERVAL = 1
) (
   input  logic              Clk,
   input  logic              Rstn_I,
   input  logic              JobVld_I,
   output logic              JobRdy_O,
   input  logic [7:0][31:0]  JobH_I,
   input  logic [15:0][31:0] JobMsg_I,
   input  logic [31:0]       JobBL_I,
   input  logic [2:0]        JobFlg_I,
   input  logic [31:0]       NonceStart_I,
   input  logic [31:0]       NonceCnt_I,
   input  logic              Abort_I,
   output logic              Strt_O,
   output logic [7:0][31:0]  H_O,
   output logic [15:0][31:0] Msg_O,
   output logic [31:0]       BL_O,
   output logic              CS_flg_O,
   output logic              CE_flg_O,
   output logic              ROOT_flg_O,
   output logic [31:0]       Nonce_O,
   output logic              Busy_O,
   output logic              Done_O
);

   localparam logic [3:0]  IDX      = NONCE_IDX[3:0];
   // GAP holds ISSUE_INTERVAL-1 cycles; the timer ticks on its zero count.
   localparam logic [31:0] GAP_LOAD = (ISSUE_INTERVAL > 1) ? 32'(ISSUE_INTERVAL - 2) : '0;

   state_t state;
   job_t   job;
   logic   tick;

   issue_timer #(.W(32)) u_timer (
      .Clk      (Clk),
      .Rstn_I   (Rstn_I),
      .load     (state == ST_ISSUE),
      .load_val (GAP_LOAD),
      .tick     (tick)
   );

   always_ff @(posedge Clk or negedge Rstn_I) begin
      if (!Rstn_I) begin
         state   <= ST_IDLE;
         job     <= '0;
         Strt_O  <= 1'b0;
         Msg_O   <= '0;
         Nonce_O <= '0;
         Done_O  <= 1'b0;
      end else begin
         Strt_O <= 1'b0;
         unique case (state)
            ST_IDLE: if (JobVld_I) begin
               job <= '{h: JobH_I, msg: JobMsg_I, bl: JobBL_I, flg: JobFlg_I,
                        nonce: NonceStart_I, cnt: NonceCnt_I};
               state <= (NonceCnt_I != '0) ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
               if (Abort_I) begin
                  state <= ST_DONE;
               end else begin
                  Strt_O    <= 1'b1;
                  Msg_O     <= insert_nonce(job.msg, IDX, job.nonce);
                  Nonce_O   <= job.nonce;
                  job.nonce <= job.nonce + 32'd1;
                  job.cnt   <= job.cnt - 32'd1;
                  if (job.cnt == 32'd1)         state <= ST_DONE;
                  else if (ISSUE_INTERVAL == 1) state <= ST_ISSUE;
                  else                          state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (Abort_I)   state <= ST_DONE;
               else if (tick) state <= ST_ISSUE;
            end
            ST_DONE: begin
               // First DONE cycle arms the pulse, second one retires to IDLE.
               if (!Done_O) begin
                  Done_O <= 1'b1;
               end else begin
                  Done_O <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign JobRdy_O   = (state == ST_IDLE);
   assign Busy_O     = (state != ST_IDLE);
   assign H_O        = job.h;
   assign BL_O       = job.bl;
   assign CS_flg_O   = job.flg[FLG_CS];
   assign CE_flg_O   = job.flg[FLG_CE];
   assign ROOT_flg_O = job.flg[FLG_ROOT];

endmodule

// File: tb/tb_job_feeder.sv
// Bench for job_feeder: two instances (interval 1 and 4) share one stimulus
// stream and are checked every cycle against a schedule-based job model.
module tb_job_feeder;

   logic              Clk = 1'b0;
   logic              Rstn_I = 1'b0;
   logic              JobVld_I = 1'b0;
   logic              Abort_I = 1'b0;
   logic [7:0][31:0]  JobH_I = '0;
   logic [15:0][31:0] JobMsg_I = '0;
   logic [31:0]       JobBL_I = '0;
   logic [2:0]        JobFlg_I = '0;
   logic [31:0]       NonceStart_I = '0;
   logic [31:0]       NonceCnt_I = '0;

   logic              rdy [2], strt [2], busy [2], done [2], cs [2], ce [2], root [2];
   logic [7:0][31:0]  h [2];
   logic [15:0][31:0] msg [2];
   logic [31:0]       bl [2], nonce [2];

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   job_feeder #(.NONCE_IDX(0), .ISSUE_INTERVAL(1)) u_dut0 (
      .Clk(Clk), .Rstn_I(Rstn_I), .JobVld_I(JobVld_I), .JobRdy_O(rdy[0]),
      .JobH_I(JobH_I), .JobMsg_I(JobMsg_I), .JobBL_I(JobBL_I), .JobFlg_I(JobFlg_I),
      .NonceStart_I(NonceStart_I), .NonceCnt_I(NonceCnt_I), .Abort_I(Abort_I),
      .Strt_O(strt[0]), .H_O(h[0]), .Msg_O(msg[0]), .BL_O(bl[0]),
      .CS_flg_O(cs[0]), .CE_flg_O(ce[0]), .ROOT_flg_O(root[0]),
      .Nonce_O(nonce[0]), .Busy_O(busy[0]), .Done_O(done[0]));

   job_feeder #(.NONCE_IDX(5), .ISSUE_INTERVAL(4)) u_dut1 (
      .Clk(Clk), .Rstn_I(Rstn_I), .JobVld_I(JobVld_I), .JobRdy_O(rdy[1]),
      .JobH_I(JobH_I), .JobMsg_I(JobMsg_I), .JobBL_I(JobBL_I), .JobFlg_I(JobFlg_I),
      .NonceStart_I(NonceStart_I), .NonceCnt_I(NonceCnt_I), .Abort_I(Abort_I),
      .Strt_O(strt[1]), .H_O(h[1]), .Msg_O(msg[1]), .BL_O(bl[1]),
      .CS_flg_O(cs[1]), .CE_flg_O(ce[1]), .ROOT_flg_O(root[1]),
      .Nonce_O(nonce[1]), .Busy_O(busy[1]), .Done_O(done[1]));

   // ---------------- schedule model ----------------
   // Edge n starts cycle n. A job accepted at edge T with n blocks issues at
   // edges T+1+k*I; the run ends at edge D (last issue or abort edge, or T
   // when n=0); Done is in cycle D+1 and the feeder is ready from cycle D+2.
   const int IVL [2] = '{1, 4};
   const int NIX [2] = '{0, 5};

   longint            cyc = 0;
   bit                m_act [2] = '{0, 0};
   bit                m_abt [2] = '{0, 0};
   longint            m_t [2] = '{0, 0};
   longint            m_n [2] = '{0, 0};
   longint            m_d [2] = '{0, 0};
   logic [31:0]       m_n0 [2];
   logic [15:0][31:0] m_tm [2];

   bit                e_strt [2] = '{0, 0};
   bit                e_done [2] = '{0, 0};
   logic [31:0]       e_non [2] = '{0, 0};
   logic [31:0]       e_bl [2] = '{0, 0};
   logic [2:0]        e_flg [2] = '{0, 0};
   logic [15:0][31:0] e_msg [2] = '{'0, '0};
   logic [7:0][31:0]  e_h [2] = '{'0, '0};

   always @(posedge Clk or negedge Rstn_I) begin
      if (!Rstn_I) begin
         for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;  m_abt[d] = 0;
            e_strt[d] = 0; e_done[d] = 0; e_non[d] = '0; e_bl[d] = '0;
            e_flg[d] = '0; e_msg[d] = '0; e_h[d] = '0;
         end
      end else begin
         cyc = cyc + 1;
         for (int d = 0; d < 2; d++) begin
            e_strt[d] = 0;
            e_done[d] = 0;
            if (m_act[d]) begin
               if (!m_abt[d] && Abort_I && cyc >= m_t[d] + 1 && cyc <= m_d[d]) begin
                  m_abt[d] = 1;
                  m_d[d]   = cyc;
               end
               if (m_n[d] > 0 && cyc >= m_t[d] + 1 && (cyc - m_t[d] - 1) % IVL[d] == 0 &&
                   (m_abt[d] ? cyc < m_d[d] : cyc <= m_d[d])) begin
                  e_strt[d] = 1;
                  e_non[d]  = m_n0[d] + 32'((cyc - m_t[d] - 1) / IVL[d]);
                  e_msg[d]  = m_tm[d];
                  e_msg[d][NIX[d]] = e_non[d];
               end
               if (cyc == m_d[d] + 1) e_done[d] = 1;
               if (cyc == m_d[d] + 2) m_act[d] = 0;
            end else if (JobVld_I) begin
               m_act[d] = 1;
               m_abt[d] = 0;
               m_t[d]   = cyc;
               m_n[d]   = longint'(NonceCnt_I);
               m_d[d]   = (m_n[d] == 0) ? cyc : cyc + 1 + (m_n[d] - 1) * IVL[d];
               m_n0[d]  = NonceStart_I;
               m_tm[d]  = JobMsg_I;
               e_h[d]   = JobH_I;
               e_bl[d]  = JobBL_I;
               e_flg[d] = JobFlg_I;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   int          lg_off [2][$];
   logic [31:0] lg_non [2][$];
   int          lg_done [2] = '{-1, -1};
   int          lg_rdy [2] = '{-1, -1};

   always @(negedge Clk) begin
      if (Rstn_I) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_strt", d),  strt[d],  e_strt[d]);
            chk($sformatf("d%0d_done", d),  done[d],  e_done[d]);
            chk($sformatf("d%0d_rdy", d),   rdy[d],   !m_act[d]);
            chk($sformatf("d%0d_busy", d),  busy[d],  m_act[d]);
            chk($sformatf("d%0d_nonce", d), nonce[d], e_non[d]);
            chk($sformatf("d%0d_msg", d),   msg[d],   e_msg[d]);
            chk($sformatf("d%0d_h", d),     h[d],     e_h[d]);
            chk($sformatf("d%0d_bl", d),    bl[d],    e_bl[d]);
            chk($sformatf("d%0d_flg", d),   {root[d], ce[d], cs[d]}, e_flg[d]);
            if (strt[d]) begin
               lg_off[d].push_back(int'(cyc - m_t[d]));
               lg_non[d].push_back(nonce[d]);
            end
            if (done[d]) lg_done[d] = int'(cyc - m_t[d]);
            if (rdy[d] && lg_rdy[d] < 0) lg_rdy[d] = int'(cyc - m_t[d]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge Clk);
      #1;
   endtask

   task automatic set_job(input logic [31:0] s, input logic [31:0] c);
      for (int w = 0; w < 8; w++)  JobH_I[w] = $urandom;
      for (int w = 0; w < 16; w++) JobMsg_I[w] = $urandom;
      JobBL_I      = $urandom_range(1, 64);
      JobFlg_I     = 3'($urandom);
      NonceStart_I = s;
      NonceCnt_I   = c;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(rdy[0] && rdy[1]) && k < 2000) begin
         step();
         k++;
      end
      if (k >= 2000) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: got busy expected ready within 2000 cycles");
      end
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         lg_off[d].delete();
         lg_non[d].delete();
         lg_done[d] = -1;
         lg_rdy[d]  = -1;
      end
   endtask

   // abt = offset of the edge (from accept) at which Abort_I is sampled, 0 = none
   task automatic go(input logic [31:0] s, input logic [31:0] c, input int abt,
                     input bit hold, input bit abt_acc);
      wait_idle();
      clear_logs();
      set_job(s, c);
      JobVld_I = 1'b1;
      Abort_I  = abt_acc;
      step();
      for (int i = 1; i <= 16; i++) begin
         Abort_I  = (i == abt);
         JobVld_I = hold && (i <= 2);
         if (hold) set_job($urandom, 32'($urandom_range(0, 5)));
         step();
      end
      Abort_I  = 1'b0;
      JobVld_I = 1'b0;
      wait_idle();
   endtask

   initial begin
      repeat (2) @(posedge Clk);
      step();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_rdy%0d", d),   rdy[d],   1'b1);
         chk($sformatf("rst_strt%0d", d),  strt[d],  1'b0);
         chk($sformatf("rst_done%0d", d),  done[d],  1'b0);
         chk($sformatf("rst_busy%0d", d),  busy[d],  1'b0);
         chk($sformatf("rst_nonce%0d", d), nonce[d], 32'h0);
      end
      Rstn_I = 1'b1;
      step();

      // three back-to-back blocks, job inputs wiggled while busy
      go(32'h10, 32'd3, 0, 1'b1, 1'b0);
      chk("t1_cnt",  lg_off[0].size(), 3);
      chk("t1_off0", lg_off[0][0], 1);
      chk("t1_off2", lg_off[0][2], 3);
      chk("t1_n0",   lg_non[0][0], 32'h10);
      chk("t1_n1",   lg_non[0][1], 32'h11);
      chk("t1_n2",   lg_non[0][2], 32'h12);
      chk("t1_done", lg_done[0], 4);
      chk("t1_rdy",  lg_rdy[0], 5);

      // nonce wrap
      go(32'hFFFFFFFE, 32'd3, 0, 1'b0, 1'b0);
      chk("t2_n0", lg_non[0][0], 32'hFFFFFFFE);
      chk("t2_n1", lg_non[0][1], 32'hFFFFFFFF);
      chk("t2_n2", lg_non[0][2], 32'h00000000);

      // interval 4 instance
      go(32'h55, 32'd2, 0, 1'b0, 1'b0);
      chk("t3_cnt",  lg_off[1].size(), 2);
      chk("t3_off0", lg_off[1][0], 1);
      chk("t3_off1", lg_off[1][1], 5);
      chk("t3_done", lg_done[1], 6);

      // abort on the 5th issue edge
      go(32'h1000, 32'd100, 5, 1'b0, 1'b0);
      chk("t4_cnt0",  lg_off[0].size(), 4);
      chk("t4_done0", lg_done[0], 6);
      chk("t4_cnt1",  lg_off[1].size(), 1);
      chk("t4_done1", lg_done[1], 6);

      // empty job with abort at accept and Vld held afterwards
      go(32'h77, 32'd0, 0, 1'b1, 1'b1);
      chk("t5_cnt",  lg_off[0].size(), 0);
      chk("t5_done", lg_done[0], 1);
      chk("t5_rdy",  lg_rdy[0], 2);

      // asynchronous reset in the middle of issuing
      wait_idle();
      set_job(32'h200, 32'd50);
      JobVld_I = 1'b1;
      step();
      JobVld_I = 1'b0;
      repeat (3) step();
      #2 Rstn_I = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("t6_strt%0d", d), strt[d], 1'b0);
         chk($sformatf("t6_rdy%0d", d),  rdy[d],  1'b1);
         chk($sformatf("t6_done%0d", d), done[d], 1'b0);
         chk($sformatf("t6_busy%0d", d), busy[d], 1'b0);
      end
      step();
      Rstn_I = 1'b1;
      go(32'h300, 32'd2, 0, 1'b0, 1'b0);
      chk("t6_next", lg_non[0][0], 32'h300);

      repeat (40) begin
         go(($urandom % 3 == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : 32'($urandom),
            32'($urandom_range(0, 12)),
            ($urandom % 4 == 0) ? int'($urandom_range(1, 15)) : 0,
            ($urandom % 4 == 0), ($urandom % 4 == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/job_feeder.md
# job_feeder

Upstream stage of the BLAKE3 hash pipeline. Accepts one mining job through a valid/ready handshake: chaining value, 16-word message template, block length, flags, nonce start and nonce count. It then issues one message block per issue slot to the hash generator, writing the current 32-bit nonce into a fixed message word. Each issued block carries its nonce as a sideband output so downstream target-check logic can tag results.

## Interface
Parameters:
- NONCE_IDX, 0, message word index (0..15) overwritten with the nonce
- ISSUE_INTERVAL, 1, cycles between consecutive Strt_O pulses (≥1)

Ports:
- Clk  in  1  clock, rising edge
- Rstn_I  in  1  reset, asynchronous, active-low
- JobVld_I  in  1  job valid
- JobRdy_O  out  1  job ready; high only in IDLE
- JobH_I  in  8x32  input chaining value
- JobMsg_I  in  16x32  message template
- JobBL_I  in  32  block length in bytes
- JobFlg_I  in  3  {ROOT, CE, CS}
- NonceStart_I  in  32  first nonce
- NonceCnt_I  in  32  number of blocks to issue; 0 means none
- Abort_I  in  1  stop issuing immediately
- Strt_O  out  1  one-cycle block-start strobe to the hash generator
- H_O  out  8x32  chaining value for the issued block
- Msg_O  out  16x32  issued message; word NONCE_IDX equals Nonce_O
- BL_O  out  32  block length
- CS_flg_O / CE_flg_O / ROOT_flg_O  out  1 each  domain flags
- Nonce_O  out  32  nonce of the block currently on Msg_O
- Busy_O  out  1  high outside IDLE
- Done_O  out  1  one-cycle pulse when a job completes or is aborted

## Operation
- FSM states:
  - IDLE: JobRdy_O=1. On JobVld_I&JobRdy_O, latch all job fields. Go to ISSUE if NonceCnt_I≠0; otherwise go to DONE.
  - ISSUE: at the edge leaving this state, register Strt_O=1, Msg_O=template with word NONCE_IDX=nonce, and Nonce_O=nonce. Then increment the nonce (mod 2^32, 0xFFFFFFFF wraps to 0) and decrement the remaining count. If remaining reaches 0, go to DONE. Otherwise go to GAP, or stay in ISSUE when ISSUE_INTERVAL=1.
  - GAP: gap counter runs ISSUE_INTERVAL-1 cycles, then return to ISSUE.
  - DONE: Done_O=1 for one cycle, then go to IDLE.
- Abort_I high in ISSUE or GAP: no further Strt_O; next state is DONE. If abort coincides with an issue edge, that block is not issued.
- Abort_I in IDLE or DONE is ignored. A job offered in the same cycle as such an abort is accepted.
- Job fields are latched at accept. Changing the Job inputs mid-job has no effect.
- H_O, BL_O, flags, Msg_O and Nonce_O hold their last values between strobes. They change only at issue edges and at job accept (H/BL/flags).
- Remaining counter is 32 bits. NonceCnt_I=0xFFFFFFFF issues 2^32-1 blocks.

## Timing
- Reset values:
  - JobRdy_O=1; all other outputs 0; FSM in IDLE.
  - Reset assertion mid-job returns to this state immediately and asynchronously, with no Done_O pulse.
- Accept at edge T, then first Strt_O high during cycle T+1 (one-cycle latency).
- Subsequent strobes every ISSUE_INTERVAL cycles. ISSUE_INTERVAL=1 gives back-to-back strobes.
- The last strobe is in cycle L, Done_O is in cycle L+1, and JobRdy_O=1 from L+2.
- NonceCnt_I=0: Done_O in T+1, JobRdy_O in T+2, no strobe.
- All outputs are registered. There is no combinational path from inputs to outputs except none (JobRdy_O decodes state).

## Structure
- Shared package (defines): FSM state enum, job struct {H, Msg, BL, flags, nonce, cnt}, flag bit positions matching the hash generator flag word.
- One sub-module, issue_timer: loadable down-counter producing the issue-slot tick for ISSUE_INTERVAL>1.
- Top-level: FSM, job register, nonce/remaining counters, output registers.

## Test plan
- Job NonceStart=0x10, NonceCnt=3, INTERVAL=1 -> Strt_O at T+1..T+3 with Nonce_O 0x10,0x11,0x12 and Msg_O[NONCE_IDX] equal; Done_O at T+4; JobRdy_O at T+5.
- NonceStart=0xFFFFFFFE, NonceCnt=3 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; other Msg words equal the template.
- INTERVAL=4, NonceCnt=2 -> strobes at T+1 and T+5 only; Done_O at T+6.
- NonceCnt=100, Abort_I pulsed in the cycle of the 5th issue edge -> exactly 4 strobes; Done_O next cycle; then IDLE.
- NonceCnt=0 -> no Strt_O; Done_O at T+1. JobVld_I held with new fields during a job -> ignored until JobRdy_O.
- Rstn_I asserted mid-ISSUE -> Strt_O=0 and JobRdy_O=1 immediately; no Done_O; next job starts cleanly.
